ones_counter_scheduler: RTL and testbench
=========================================

Name: ones_counter_scheduler

Overview:
Shares one ones_counter instance among NUM_REQ requesters using round-robin arbitration. Each requester presents an INPUT_FEATURES-bit feature word with a req/grant handshake. The block latches the granted word and drives it into the shared counter. It then waits out the counter latency and returns the popcount, tagged with the requester id. It sits between the feature-extraction front ends and the classification logic.

Parameters:
INPUT_FEATURES, 8, width of each feature word (same meaning as in ones_counter)
NUM_REQ, 4, number of requesters; must be ≥2
COUNTER_LATENCY, 1, clock edges from ones_counter input change to valid ones_o; must be ≥1

Ports:
clock_i  in  1  system clock, rising edge
reset_i  in  1  asynchronous, active-low reset
req_i  in  NUM_REQ  per-requester request level; feature word must be stable while high
features_i  in  NUM_REQ*INPUT_FEATURES  packed feature words; requester k uses bits [k*INPUT_FEATURES +: INPUT_FEATURES]
grant_o  out  NUM_REQ  one-hot, single-cycle pulse: the requester's word was sampled
busy_o  out  1  a transaction is in flight
result_valid_o  out  1  single-cycle pulse: result_ones_o and result_id_o are valid
result_id_o  out  $clog2(NUM_REQ)  index of the requester that owns the result
result_ones_o  out  $clog2(INPUT_FEATURES+1)  number of ones in the sampled word

Behaviour:
- Reset (reset_i low, takes effect immediately): all outputs 0.
  - State IDLE, round-robin pointer 0, feature latch 0.
  - The internal ones_counter is reset with the inverted reset_i.
- FSM states: IDLE, COUNT, RESULT. All outputs are registered.
- IDLE, any req_i high at edge E0:
  - Select the first requester with req high, searching upward from the pointer and wrapping modulo NUM_REQ.
  - At E0: grant_o[k]=1 for exactly one cycle, feature latch <= word k, id latch <= k, busy_o=1, wait counter <= COUNTER_LATENCY, go to COUNT.
  - The pointer becomes (k+1) mod NUM_REQ.
- COUNT: the feature latch drives the counter input; the wait counter decrements each edge. When it reaches 0, go to RESULT.
- RESULT edge (E0+COUNTER_LATENCY+1):
  - result_valid_o=1 for one cycle, with result_ones_o=counter output and result_id_o=id latch.
  - busy_o=0; state returns to IDLE.
- The earliest next grant is the edge after result_valid_o. The minimum grant-to-grant spacing is COUNTER_LATENCY+2 cycles.
- result_ones_o and result_id_o hold their last value between pulses. result_valid_o is the only qualifier.
- Requester obligations:
  - Hold req_i and the word stable until grant_o[k].
  - Deassert req_i in the cycle grant_o[k] is seen, or hold it high to request again.
  - A req_i that drops before a grant is simply never served; no error is flagged.
- req_i changes while busy_o=1 are ignored and re-evaluated in IDLE.
- The requester granted last gets lowest priority next; no starvation.
- All req_i low in IDLE: hold state; pointer unchanged.
- Reset asserted mid-transaction: the transaction is dropped. No result_valid_o is issued for it, and the pointer returns to 0.
- Width rules:
  - result_ones_o is zero-extended from the counter output.
  - The all-ones word gives INPUT_FEATURES (8 → 4'b1000) with no overflow.

Decomposition:
- Shared package holds:
  - the ONES_W width function, $clog2(INPUT_FEATURES+1);
  - the ID_W width function, $clog2(NUM_REQ);
  - the state encoding constants (IDLE=2'd0, COUNT=2'd1, RESULT=2'd2).
- Sub-module: a round-robin arbiter, rr_arbiter (inputs req and pointer; outputs one-hot grant and index). It is combinational, reusable and tested standalone.
- The existing ones_counter is instantiated once, unmodified.

Test Plan:
1. Single request: after reset release, req_i=4'b0001, word0=8'b00101101. Expect grant_o=0001 for 1 cycle, then result_valid_o exactly 2 cycles later with id=0, ones=4.
2. Round-robin with all requesting: req_i=4'b1111 held. Words are 8'h00, 8'h01, 8'h0E, 8'hFF for requesters 0..3. Expect results in order id 0,1,2,3,0 with ones 0,1,3,8,0; grants spaced 3 cycles apart.
3. Fairness after wrap: requester 2 is served, then req_i=4'b0101. Expect the next grant to id 0, then id 2.
4. Boundary values: word 8'hFF → ones=8 (4'b1000); word 8'h00 → ones=0. result_ones_o holds its value between pulses.
5. Request withdrawn: req_i[1] pulses high for one cycle while busy_o=1, then drops. Expect no grant and no result for id 1.
6. Reset mid-operation: reset_i low for 1 cycle in COUNT. Expect all outputs 0 immediately and no result_valid_o. The next request from id 3 with req_i=4'b1001 after release grants id 0 first, confirming the pointer reset.

Source files
------------

// File: rtl/ones_counter_scheduler_pkg.sv
// Shared types and width helpers for the ones_counter scheduler slice.
package ones_counter_scheduler_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        COUNT  = 2'd1,
        RESULT = 2'd2
    } state_t;

    function automatic int ones_w(input int features);
        return $clog2(features + 1);
    endfunction

    function automatic int id_w(input int num_req);
        return $clog2(num_req);
    endfunction

    function automatic int wait_w(input int latency);
        return $clog2(latency + 1);
    endfunction

endpackage

// File: rtl/ones_counter_scheduler_if.sv
// Requester-side bus of the scheduler: request/grant handshake plus tagged result.
interface ones_counter_scheduler_if #(
    parameter int INPUT_FEATURES = 8,
    parameter int NUM_REQ        = 4
);
    import ones_counter_scheduler_pkg::*;

    localparam int ONES_W = ones_w(INPUT_FEATURES);
    localparam int ID_W   = id_w(NUM_REQ);

    logic [NUM_REQ-1:0]                req_i;
    logic [NUM_REQ*INPUT_FEATURES-1:0] features_i;
    logic [NUM_REQ-1:0]                grant_o;
    logic                              busy_o;
    logic                              result_valid_o;
    logic [ID_W-1:0]                   result_id_o;
    logic [ONES_W-1:0]                 result_ones_o;

    modport master (
        output req_i, features_i,
        input  grant_o, busy_o, result_valid_o, result_id_o, result_ones_o
    );

    modport slave (
        input  req_i, features_i,
        output grant_o, busy_o, result_valid_o, result_id_o, result_ones_o
    );

endinterface

// File: rtl/ones_counter.sv
// Population counter with a LATENCY-deep registered output pipeline.
module ones_counter #(
    parameter int  INPUT_FEATURES = 8,
    parameter int  LATENCY        = 1,
    localparam int ONES_W         = $clog2(INPUT_FEATURES + 1)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [INPUT_FEATURES-1:0] features_i,
    output logic [ONES_W-1:0]         ones_o
);

    logic [ONES_W-1:0] count_d;
    logic [ONES_W-1:0] pipe_q [LATENCY];

    always_comb begin
        count_d = '0;
        for (int unsigned i = 0; i < INPUT_FEATURES; i++) begin
            count_d = count_d + ONES_W'(features_i[i]);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < LATENCY; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q[0] <= count_d;
            for (int unsigned i = 1; i < LATENCY; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign ones_o = pipe_q[LATENCY-1];

endmodule

// File: rtl/ones_counter_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or above ptr_i, wrapping.
module rr_arbiter
    import ones_counter_scheduler_pkg::*;
#(
    parameter int NUM_REQ = 4,
    localparam int ID_W   = id_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [ID_W-1:0]    idx_o,
    output logic               valid_o
);

    int unsigned     cand_int;
    logic [ID_W-1:0] cand_idx;

    always_comb begin
        grant_o  = '0;
        idx_o    = '0;
        valid_o  = 1'b0;
        cand_int = '0;
        cand_idx = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand_int = (32'(ptr_i) + i) % 32'(NUM_REQ);
            cand_idx = ID_W'(cand_int);
            if (!valid_o && req_i[cand_idx]) begin
                valid_o           = 1'b1;
                grant_o[cand_idx] = 1'b1;
                idx_o             = cand_idx;
            end
        end
    end

endmodule

// File: rtl/ones_counter_scheduler.sv
// Time-shares one ones_counter among NUM_REQ requesters with round-robin grants
// and returns each popcount tagged with the owning requester id.
module ones_counter_scheduler
    import ones_counter_scheduler_pkg::*;
#(
    parameter int INPUT_FEATURES  = 8,
    parameter int NUM_REQ         = 4,
    parameter int COUNTER_LATENCY = 1
) (
    input  logic                    clock_i,
    input  logic                    reset_i,
    ones_counter_scheduler_if.slave bus
);

    localparam int ONES_W = ones_w(INPUT_FEATURES);
    localparam int ID_W   = id_w(NUM_REQ);
    localparam int WAIT_W = wait_w(COUNTER_LATENCY);

    state_t                    state_q;
    logic [ID_W-1:0]           ptr_q;
    logic [INPUT_FEATURES-1:0] feat_q;
    logic [ID_W-1:0]           id_q;
    logic [WAIT_W-1:0]         wait_q;
    logic [NUM_REQ-1:0]        grant_q;
    logic                      busy_q;
    logic                      valid_q;
    logic [ID_W-1:0]           res_id_q;
    logic [ONES_W-1:0]         res_ones_q;

    logic [NUM_REQ-1:0]        arb_grant;
    logic [ID_W-1:0]           arb_idx;
    logic                      arb_valid;
    logic [INPUT_FEATURES-1:0] sel_word_d;
    logic [ID_W-1:0]           ptr_d;
    logic [ONES_W-1:0]         cnt_ones;
    logic                      cnt_rst;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req_i   (bus.req_i),
        .ptr_i   (ptr_q),
        .grant_o (arb_grant),
        .idx_o   (arb_idx),
        .valid_o (arb_valid)
    );

    assign cnt_rst = ~reset_i;

    ones_counter #(
        .INPUT_FEATURES (INPUT_FEATURES),
        .LATENCY        (COUNTER_LATENCY)
    ) u_cnt (
        .clk_i      (clock_i),
        .rst_i      (cnt_rst),
        .features_i (feat_q),
        .ones_o     (cnt_ones)
    );

    // One-hot mux keeps every slice index constant.
    always_comb begin
        sel_word_d = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (arb_grant[i]) begin
                sel_word_d = bus.features_i[i*INPUT_FEATURES +: INPUT_FEATURES];
            end
        end
    end

    always_comb begin
        ptr_d = '0;
        if (arb_idx != ID_W'(NUM_REQ - 1)) begin
            ptr_d = arb_idx + ID_W'(1);
        end
    end

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            feat_q     <= '0;
            id_q       <= '0;
            wait_q     <= '0;
            grant_q    <= '0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
            res_id_q   <= '0;
            res_ones_q <= '0;
        end else begin
            grant_q <= '0;
            valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (arb_valid) begin
                        grant_q <= arb_grant;
                        feat_q  <= sel_word_d;
                        id_q    <= arb_idx;
                        ptr_q   <= ptr_d;
                        wait_q  <= WAIT_W'(COUNTER_LATENCY);
                        busy_q  <= 1'b1;
                        state_q <= COUNT;
                    end
                end
                COUNT: begin
                    // Leave on the edge that takes the wait counter to zero.
                    wait_q <= wait_q - WAIT_W'(1);
                    if (wait_q == WAIT_W'(1)) begin
                        state_q <= RESULT;
                    end
                end
                RESULT: begin
                    valid_q    <= 1'b1;
                    res_ones_q <= cnt_ones;
                    res_id_q   <= id_q;
                    busy_q     <= 1'b0;
                    state_q    <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.grant_o        = grant_q;
    assign bus.busy_o         = busy_q;
    assign bus.result_valid_o = valid_q;
    assign bus.result_id_o    = res_id_q;
    assign bus.result_ones_o  = res_ones_q;

endmodule

// File: tb/tb_ones_counter_scheduler.sv
// Directed scenarios plus randomized traffic against a timestamp-based reference model.
module tb_ones_counter_scheduler;

    localparam int FW = 8;
    localparam int NR = 4;
    localparam int L  = 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    logic [FW-1:0] word [NR];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ones_counter_scheduler_if #(.INPUT_FEATURES(FW), .NUM_REQ(NR)) bus ();

    for (genvar k = 0; k < NR; k++) begin : g_feat
        assign bus.features_i[k*FW +: FW] = word[k];
    end

    ones_counter_scheduler #(
        .INPUT_FEATURES  (FW),
        .NUM_REQ         (NR),
        .COUNTER_LATENCY (L)
    ) dut (
        .clock_i (clk),
        .reset_i (rst_n),
        .bus     (bus)
    );

    // Reference model: one transaction at a time, result L+1 edges after its grant.
    int            m_cyc, m_done_at, m_ptr, m_id;
    bit            m_active;
    logic [FW-1:0] m_word;
    logic [NR-1:0] e_grant;
    logic          e_busy, e_valid;
    logic [1:0]    e_id;
    logic [3:0]    e_ones;

    always @(posedge clk or negedge rst_n) begin : model
        int  k;
        int  c;
        bit  found;
        if (!rst_n) begin
            m_cyc <= 0; m_done_at <= 0; m_ptr <= 0; m_id <= 0; m_active <= 1'b0; m_word <= '0;
            e_grant <= '0; e_busy <= 1'b0; e_valid <= 1'b0; e_id <= '0; e_ones <= '0;
        end else begin
            m_cyc   <= m_cyc + 1;
            e_grant <= '0;
            e_valid <= 1'b0;
            if (m_active) begin
                if (m_cyc == m_done_at) begin
                    e_valid  <= 1'b1;
                    e_id     <= 2'(m_id);
                    e_ones   <= 4'($countones(m_word));
                    e_busy   <= 1'b0;
                    m_active <= 1'b0;
                end
            end else begin
                found = 1'b0;
                k = 0;
                for (int i = 0; i < NR; i++) begin
                    c = (m_ptr + i) % NR;
                    if (!found && bus.req_i[c]) begin
                        found = 1'b1;
                        k = c;
                    end
                end
                if (found) begin
                    e_grant   <= NR'(1 << k);
                    e_busy    <= 1'b1;
                    m_active  <= 1'b1;
                    m_done_at <= m_cyc + L + 1;
                    m_id      <= k;
                    m_word    <= word[k];
                    m_ptr     <= (k + 1) % NR;
                end
            end
        end
    end

    task automatic wait_grant(input int budget, output logic [NR-1:0] g);
        g = '0;
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if (bus.grant_o != '0) begin
                g = bus.grant_o;
                return;
            end
        end
    endtask

    task automatic wait_valid(input int budget, output bit seen);
        seen = 1'b0;
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if (bus.result_valid_o) begin
                seen = 1'b1;
                return;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.req_i = '0;
        for (int k = 0; k < NR; k++) word[k] = '0;
        repeat (3) @(negedge clk);
        checks++; if (bus.grant_o !== 4'b0000) begin errors++; $display("FAIL reset_grant: got %b expected 0000", bus.grant_o); end
        checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy_o); end
        checks++; if (bus.result_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.result_valid_o); end
        checks++; if (bus.result_id_o !== 2'd0) begin errors++; $display("FAIL reset_id: got %0d expected 0", bus.result_id_o); end
        checks++; if (bus.result_ones_o !== 4'd0) begin errors++; $display("FAIL reset_ones: got %0d expected 0", bus.result_ones_o); end
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        logic [NR-1:0] g;
        word[0] = 8'b00101101;
        bus.req_i = 4'b0001;
        wait_grant(10, g);
        checks++; if (g !== 4'b0001) begin errors++; $display("FAIL single_grant: got %b expected 0001", g); end
        bus.req_i = '0;
        @(negedge clk);
        checks++; if (bus.grant_o !== 4'b0000 || bus.result_valid_o !== 1'b0 || bus.busy_o !== 1'b1)
            begin errors++; $display("FAIL single_gap: grant %b valid %b busy %b, expected 0000 0 1", bus.grant_o, bus.result_valid_o, bus.busy_o); end
        @(negedge clk);
        checks++; if (bus.result_valid_o !== 1'b1) begin errors++; $display("FAIL single_valid_time: got %b expected 1", bus.result_valid_o); end
        checks++; if (bus.result_id_o !== 2'd0 || bus.result_ones_o !== 4'd4)
            begin errors++; $display("FAIL single_result: id %0d ones %0d, expected id 0 ones 4", bus.result_id_o, bus.result_ones_o); end
        @(negedge clk);
        checks++; if (bus.result_valid_o !== 1'b0 || bus.result_ones_o !== 4'd4)
            begin errors++; $display("FAIL single_pulse: valid %b ones %0d, expected 0 and 4", bus.result_valid_o, bus.result_ones_o); end
    endtask

    task automatic test_round_robin();
        logic [NR-1:0] g;
        bit seen;
        int prev;
        int exp_id   [5] = '{0, 1, 2, 3, 0};
        int exp_ones [5] = '{0, 1, 3, 8, 0};
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        word[0] = 8'h00; word[1] = 8'h01; word[2] = 8'h0E; word[3] = 8'hFF;
        bus.req_i = 4'b1111;
        prev = 0;
        for (int i = 0; i < 5; i++) begin
            wait_grant(10, g);
            checks++; if (g !== NR'(1 << exp_id[i])) begin errors++; $display("FAIL rr_grant[%0d]: got %b expected id %0d", i, g, exp_id[i]); end
            if (i > 0) begin
                checks++; if (cyc - prev !== 3) begin errors++; $display("FAIL rr_spacing[%0d]: got %0d expected 3", i, cyc - prev); end
            end
            prev = cyc;
            if (i == 4) bus.req_i = '0;
            wait_valid(6, seen);
            checks++; if (!seen || bus.result_id_o !== 2'(exp_id[i]) || bus.result_ones_o !== 4'(exp_ones[i]))
                begin errors++; $display("FAIL rr_result[%0d]: seen %0b id %0d ones %0d, expected id %0d ones %0d",
                                         i, seen, bus.result_id_o, bus.result_ones_o, exp_id[i], exp_ones[i]); end
        end
    endtask

    task automatic test_fairness();
        logic [NR-1:0] g;
        bit seen;
        word[2] = 8'hA5;
        bus.req_i = 4'b0100;
        wait_grant(10, g);
        checks++; if (g !== 4'b0100) begin errors++; $display("FAIL fair_setup: got %b expected 0100", g); end
        bus.req_i = '0;
        wait_valid(6, seen);
        word[0] = 8'h3C;
        bus.req_i = 4'b0101;
        wait_grant(10, g);
        checks++; if (g !== 4'b0001) begin errors++; $display("FAIL fair_first: got %b expected 0001", g); end
        bus.req_i = 4'b0100;
        wait_grant(10, g);
        checks++; if (g !== 4'b0100) begin errors++; $display("FAIL fair_second: got %b expected 0100", g); end
        bus.req_i = '0;
        wait_valid(6, seen);
        checks++; if (!seen || bus.result_id_o !== 2'd2 || bus.result_ones_o !== 4'd4)
            begin errors++; $display("FAIL fair_result: seen %0b id %0d ones %0d, expected id 2 ones 4", seen, bus.result_id_o, bus.result_ones_o); end
    endtask

    task automatic test_boundary();
        logic [NR-1:0] g;
        bit seen;
        word[1] = 8'hFF;
        bus.req_i = 4'b0010;
        wait_grant(10, g);
        checks++; if (g !== 4'b0010) begin errors++; $display("FAIL bound_grant_ff: got %b expected 0010", g); end
        bus.req_i = '0;
        wait_valid(6, seen);
        checks++; if (!seen || bus.result_ones_o !== 4'b1000 || bus.result_id_o !== 2'd1)
            begin errors++; $display("FAIL bound_ff: seen %0b ones %b id %0d, expected ones 1000 id 1", seen, bus.result_ones_o, bus.result_id_o); end
        repeat (3) begin
            @(negedge clk);
            checks++; if (bus.result_valid_o !== 1'b0 || bus.result_ones_o !== 4'b1000)
                begin errors++; $display("FAIL bound_hold: valid %b ones %b, expected 0 and 1000", bus.result_valid_o, bus.result_ones_o); end
        end
        word[3] = 8'h00;
        bus.req_i = 4'b1000;
        wait_grant(10, g);
        bus.req_i = '0;
        wait_valid(6, seen);
        checks++; if (!seen || bus.result_ones_o !== 4'd0 || bus.result_id_o !== 2'd3)
            begin errors++; $display("FAIL bound_00: seen %0b ones %0d id %0d, expected ones 0 id 3", seen, bus.result_ones_o, bus.result_id_o); end
    endtask

    task automatic test_withdrawn();
        logic [NR-1:0] g;
        int n_grant1, n_valid;
        word[0] = 8'($urandom);
        bus.req_i = 4'b0001;
        wait_grant(10, g);
        checks++; if (g !== 4'b0001) begin errors++; $display("FAIL wd_grant: got %b expected 0001", g); end
        bus.req_i = 4'b0010;
        checks++; if (bus.busy_o !== 1'b1) begin errors++; $display("FAIL wd_busy: got %b expected 1", bus.busy_o); end
        @(negedge clk);
        bus.req_i = '0;
        n_grant1 = 0;
        n_valid  = 0;
        repeat (8) begin
            if (bus.grant_o[1]) n_grant1++;
            if (bus.result_valid_o) begin
                n_valid++;
                checks++; if (bus.result_id_o !== 2'd0 || 32'(bus.result_ones_o) !== $countones(word[0]))
                    begin errors++; $display("FAIL wd_result: id %0d ones %0d, expected id 0 ones %0d", bus.result_id_o, bus.result_ones_o, $countones(word[0])); end
            end
            @(negedge clk);
        end
        checks++; if (n_grant1 !== 0) begin errors++; $display("FAIL wd_no_grant: got %0d grants expected 0", n_grant1); end
        checks++; if (n_valid !== 1) begin errors++; $display("FAIL wd_valid_count: got %0d expected 1", n_valid); end
    endtask

    task automatic test_reset_mid();
        logic [NR-1:0] g;
        bit seen;
        int n_valid;
        word[3] = 8'h0F;
        bus.req_i = 4'b1000;
        wait_grant(10, g);
        checks++; if (g !== 4'b1000) begin errors++; $display("FAIL rst_mid_grant: got %b expected 1000", g); end
        bus.req_i = '0;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus.grant_o !== '0 || bus.busy_o !== 1'b0 || bus.result_valid_o !== 1'b0 ||
                      bus.result_id_o !== '0 || bus.result_ones_o !== '0)
            begin errors++; $display("FAIL rst_mid_outputs: grant %b busy %b valid %b id %0d ones %0d, expected all 0",
                                     bus.grant_o, bus.busy_o, bus.result_valid_o, bus.result_id_o, bus.result_ones_o); end
        @(negedge clk);
        rst_n = 1'b1;
        n_valid = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.result_valid_o) n_valid++;
        end
        checks++; if (n_valid !== 0) begin errors++; $display("FAIL rst_mid_dropped: got %0d results expected 0", n_valid); end
        word[0] = 8'h81;
        bus.req_i = 4'b1001;
        wait_grant(10, g);
        checks++; if (g !== 4'b0001) begin errors++; $display("FAIL rst_mid_ptr: got %b expected 0001", g); end
        bus.req_i = 4'b1000;
        wait_grant(10, g);
        checks++; if (g !== 4'b1000) begin errors++; $display("FAIL rst_mid_next: got %b expected 1000", g); end
        bus.req_i = '0;
        wait_valid(6, seen);
        checks++; if (!seen || bus.result_id_o !== 2'd3 || bus.result_ones_o !== 4'd4)
            begin errors++; $display("FAIL rst_mid_result: seen %0b id %0d ones %0d, expected id 3 ones 4", seen, bus.result_id_o, bus.result_ones_o); end
    endtask

    task automatic test_random();
        logic [NR-1:0] r;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            checks++; if (bus.grant_o !== e_grant) begin errors++; $display("FAIL rnd_grant @%0d: got %b expected %b", cyc, bus.grant_o, e_grant); end
            checks++; if (bus.busy_o !== e_busy) begin errors++; $display("FAIL rnd_busy @%0d: got %b expected %b", cyc, bus.busy_o, e_busy); end
            checks++; if (bus.result_valid_o !== e_valid) begin errors++; $display("FAIL rnd_valid @%0d: got %b expected %b", cyc, bus.result_valid_o, e_valid); end
            checks++; if (bus.result_id_o !== e_id) begin errors++; $display("FAIL rnd_id @%0d: got %0d expected %0d", cyc, bus.result_id_o, e_id); end
            checks++; if (bus.result_ones_o !== e_ones) begin errors++; $display("FAIL rnd_ones @%0d: got %0d expected %0d", cyc, bus.result_ones_o, e_ones); end
            r = bus.req_i;
            for (int k = 0; k < NR; k++) begin
                if (r[k]) begin
                    if (bus.grant_o[k]) begin
                        if ($urandom_range(1) == 0) r[k] = 1'b0;
                    end else if ($urandom_range(30) == 0) begin
                        r[k] = 1'b0;
                    end
                end else if ($urandom_range(3) == 0) begin
                    r[k]    = 1'b1;
                    word[k] = 8'($urandom);
                end
            end
            bus.req_i = r;
        end
        bus.req_i = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_fairness();
        test_boundary();
        test_withdrawn();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
